// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: ALU control codes, RV32I opcodes and shared decode types
package alu_issue_stage_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic [31:0] i;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] u;
    logic [31:0] j;
  } imm_t;
  typedef struct packed {
    logic [3:0]  control;
    logic [31:0] a;
    logic [31:0] b;
    logic        cmp;
    logic        eq;
    logic        br;
    logic        ill;
  } issue_t;
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream operands, flush and registered ALU-side handshake bundle
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ScrA;
  logic [31:0] ScrB;
  logic [3:0]  control;
  logic        Comparatorenable;
  logic        equal_inequal;
  logic        is_branch;
  logic        illegal;
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, ScrA, ScrB, control, Comparatorenable, equal_inequal, is_branch, illegal
  );
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, ScrA, ScrB, control, Comparatorenable, equal_inequal, is_branch, illegal
  );
endinterface

// File: rtl/alu_issue_stage_imm_gen.sv
// alu_issue_stage_imm_gen: sign-extended RV32I I/S/B/U/J immediates
module alu_issue_stage_imm_gen
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  output imm_t        imm
);
  assign imm.i = {{20{instr[31]}}, instr[31:20]};
  assign imm.s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm.b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm.u = {instr[31:12], 12'b0};
  assign imm.j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I into ALU control/operands and registers them behind a valid/ready stage
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   io
);
  imm_t        imm;
  issue_t      d;
  issue_t      q;
  logic        v;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        sh;
  logic        unused_ok;
  alu_issue_stage_imm_gen u_imm (.instr(io.instr), .imm(imm));
  assign opc = io.instr[6:0];
  assign f3  = io.instr[14:12];
  assign f7  = io.instr[31:25];
  assign sh  = f3[1:0] == 2'b01;
  assign unused_ok = ^{imm.b, imm.j, RESET_PC, 32'(XLEN)};
  always_comb begin
    d = '0;
    d.control = ALU_ADD;
    case (opc)
      OPC_OP: begin
        d.a = io.rs1_data;
        d.b = sh ? {27'b0, io.rs2_data[4:0]} : io.rs2_data;
        d.control = alu_map(f3, f7[5]);
        d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_IMM: begin
        d.a = io.rs1_data;
        d.b = sh ? {27'b0, io.instr[24:20]} : imm.i;
        d.control = alu_map(f3, f3 == 3'b101 && f7[5]);
      end
      OPC_BRANCH: begin
        d.a = io.rs1_data;
        d.b = io.rs2_data;
        d.cmp = 1'b1;
        d.br = 1'b1;
        d.eq = !f3[0];
        d.control = f3[2:1] == 2'b00 ? ALU_XOR : f3[1] ? ALU_SLTU : ALU_SLT;
        d.ill = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        d.a = io.rs1_data;
        d.b = imm.i;
      end
      OPC_STORE: begin
        d.a = io.rs1_data;
        d.b = imm.s;
      end
      OPC_LUI: d.b = imm.u;
      OPC_AUIPC: begin
        d.a = io.pc;
        d.b = imm.u;
      end
      OPC_JAL, OPC_JALR: begin
        d.a = io.pc;
        d.b = 32'd4;
      end
      default: d.ill = 1'b1;
    endcase
    if (d.ill) begin
      d = '0;
      d.ill = 1'b1;
    end
  end
  assign io.in_ready = !io.flush && (!v || io.out_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      q <= '0;
    end else if (io.flush) begin
      v <= 1'b0;
    end else if (io.in_valid && io.in_ready) begin
      v <= 1'b1;
      q <= d;
    end else if (io.out_ready) begin
      v <= 1'b0;
    end
  end
  assign io.out_valid        = v;
  assign io.ScrA             = q.a;
  assign io.ScrB             = q.b;
  assign io.control          = q.control;
  assign io.Comparatorenable = q.cmp;
  assign io.equal_inequal    = q.eq;
  assign io.is_branch        = q.br;
  assign io.illegal          = q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scoreboard bench for the ALU issue stage
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_issue_stage_if io();
  alu_issue_stage dut (.clk(clk), .rst(rst), .io(io));
  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic        cmp;
    logic        eq;
    logic        br;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                              logic cmp = 0, logic eq = 0, logic br = 0, logic ill = 0);
    exp_t e;
    e.c = c; e.a = a; e.b = b; e.cmp = cmp; e.eq = eq; e.br = br; e.ill = ill;
    return e;
  endfunction
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 32'(io.out_valid), 32'd1);
    chk({tag, ".sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, ".control"}, 32'(io.control), 32'(e.c));
    chk({tag, ".ScrA"}, io.ScrA, e.a);
    chk({tag, ".ScrB"}, io.ScrB, e.b);
    chk({tag, ".cmp"}, 32'(io.Comparatorenable), 32'(e.cmp));
    chk({tag, ".eq"}, 32'(io.equal_inequal), 32'(e.eq));
    chk({tag, ".br"}, 32'(io.is_branch), 32'(e.br));
    chk({tag, ".ill"}, 32'(io.illegal), 32'(e.ill));
  endtask
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    @(negedge clk);
    io.in_valid = 1'b1; io.instr = ins; io.pc = p; io.rs1_data = r1; io.rs2_data = r2;
    io.out_ready = 1'b1;
    sb.push_back(e);
    #1 chk({tag, ".in_ready"}, 32'(io.in_ready), 32'd1);
    @(negedge clk);
    io.in_valid = 1'b0;
    check_out(tag);
  endtask
  initial begin
    io.in_valid = 0; io.instr = 0; io.pc = 0; io.rs1_data = 0; io.rs2_data = 0;
    io.flush = 0; io.out_ready = 1;
    @(posedge clk);
    #1;
    chk("rst.valid", 32'(io.out_valid), 32'd0);
    chk("rst.control", 32'(io.control), 32'd0);
    chk("rst.ScrA", io.ScrA, 32'd0);
    chk("rst.ScrB", io.ScrB, 32'd0);
    chk("rst.ill", 32'(io.illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue("add",   32'h002081B3, 32'h0,   32'd5,        32'd7,        mk(4'b0010, 32'd5, 32'd7));
    issue("sub",   32'h402081B3, 32'h0,   32'h50,       32'h40,       mk(4'b0110, 32'h50, 32'h40));
    issue("sra",   32'h4020D1B3, 32'h0,   32'h80000000, 32'h123,      mk(4'b1001, 32'h80000000, 32'h3));
    issue("bgeu",  32'h0020F063, 32'h0,   32'd1,        32'd2,        mk(4'b0111, 32'd1, 32'd2, 1, 0, 1));
    issue("beq",   32'h00208063, 32'h0,   32'd4,        32'd4,        mk(4'b0011, 32'd4, 32'd4, 1, 1, 1));
    issue("blt",   32'h0020C063, 32'h0,   32'd3,        32'd9,        mk(4'b0101, 32'd3, 32'd9, 1, 1, 1));
    issue("br010", 32'h0020A063, 32'h0,   32'd3,        32'd9,        mk(4'b0000, 32'd0, 32'd0, 0, 0, 0, 1));
    issue("lui",   32'h123450B7, 32'h0,   32'hAA,       32'hBB,       mk(4'b0010, 32'd0, 32'h12345000));
    issue("auipc", 32'h00001097, 32'h100, 32'hAA,       32'hBB,       mk(4'b0010, 32'h100, 32'h1000));
    issue("addi",  32'hFFF10093, 32'h0,   32'h10,       32'hBB,       mk(4'b0010, 32'h10, 32'hFFFFFFFF));
    issue("srai",  32'h40515093, 32'h0,   32'hF0,       32'hBB,       mk(4'b1001, 32'hF0, 32'd5));
    issue("sw",    32'h0020A423, 32'h0,   32'h1000,     32'hDEAD,     mk(4'b0010, 32'h1000, 32'd8));
    issue("jal",   32'h0000006F, 32'h200, 32'hAA,       32'hBB,       mk(4'b0010, 32'h200, 32'd4));
    issue("mul",   32'h022081B3, 32'h0,   32'd5,        32'd7,        mk(4'b0000, 32'd0, 32'd0, 0, 0, 0, 1));
    issue("op7f",  32'h0000007F, 32'h0,   32'd5,        32'd7,        mk(4'b0000, 32'd0, 32'd0, 0, 0, 0, 1));
    @(negedge clk);
    io.in_valid = 1'b1; io.instr = 32'h002081B3; io.rs1_data = 32'd9; io.rs2_data = 32'd1;
    io.out_ready = 1'b0;
    sb.push_back(mk(4'b0010, 32'd9, 32'd1));
    @(negedge clk);
    io.instr = 32'h402081B3; io.rs1_data = 32'd3;
    check_out("stall");
    for (int i = 0; i < 3; i++) begin
      chk("stall.in_ready", 32'(io.in_ready), 32'd0);
      chk("stall.valid", 32'(io.out_valid), 32'd1);
      chk("stall.ScrA", io.ScrA, 32'd9);
      chk("stall.control", 32'(io.control), 32'b0010);
      @(negedge clk);
    end
    io.flush = 1'b1;
    #1 chk("flush.in_ready", 32'(io.in_ready), 32'd0);
    @(negedge clk);
    io.flush = 1'b0; io.in_valid = 1'b0;
    chk("flush.valid", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    io.in_valid = 1'b1; io.instr = 32'h123450B7; io.out_ready = 1'b0;
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("rststall.valid", 32'(io.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rststall.async_valid", 32'(io.out_valid), 32'd0);
    chk("rststall.async_ScrB", io.ScrB, 32'd0);
    @(negedge clk);
    rst = 1'b0; io.out_ready = 1'b1;
    issue("recover", 32'h002081B3, 32'h0, 32'd11, 32'd22, mk(4'b0010, 32'd11, 32'd22));
    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
